// File: rtl/slice_loader.sv
// Line-memory loader: accepts cfg_count lines from upstream, writes them to the line memory,
// kicks the downstream rotation controller and waits for its done. Optional parity check: SLICE_LOADER_PARITY_EN.
module slice_loader #(
  parameter int SIZE    = 5,
  parameter int MEMSIZE = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [5:0]         cfg_count,
  input  logic               in_valid,
  input  logic [MEMSIZE-1:0] in_line,
  output logic               in_ready,
  output logic               mem_we,
  output logic [5:0]         mem_addr,
  output logic [MEMSIZE-1:0] mem_wdata,
  output logic               start,
  output logic [5:0]         count,
  input  logic               done,
  output logic               busy,
  output logic               loaded
`ifdef SLICE_LOADER_PARITY_EN
  ,
  input  logic               in_parity,
  output logic               par_err
`endif
);

  // A line is one SIZE x SIZE bit slice; a mismatched pair is a configuration error.
  if (SIZE * SIZE != MEMSIZE) begin : g_bad_cfg
    $error("slice_loader: MEMSIZE must equal SIZE*SIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    KICK = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [5:0] count_q, count_d;
  logic       accept;
  logic       last_line;

  assign accept    = (state_q == LOAD) && in_valid;
  // count_q - 1 wraps to 63 for a count of 0, which encodes a 64-line load.
  assign last_line = (addr_q == (count_q - 6'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 6'd0;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    in_ready = 1'b0;
    start    = 1'b0;
    loaded   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          count_d = cfg_count;
          addr_d  = 6'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d = addr_q + 6'd1;
          if (last_line) state_d = KICK;
        end
      end
      KICK: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          loaded  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port is gated so it reads all-zero whenever no line is being accepted.
  assign mem_we    = accept;
  assign mem_addr  = accept ? addr_q : 6'd0;
  assign mem_wdata = accept ? in_line : '0;
  assign count     = count_q;
  assign busy      = (state_q != IDLE);

`ifdef SLICE_LOADER_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    par_err_d = par_err_q;
    if ((state_q == IDLE) && go) par_err_d = 1'b0;
    else if (accept && ((^in_line) != in_parity)) par_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_q <= 1'b0;
    else      par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  // Parity checking is not built in this configuration.
`endif

endmodule

// File: doc/slice_loader.md
SLICE_LOADER -- requirements
Module: slice_loader

Interface
REQ-001 SHALL have parameter SIZE, default 5, lane dimension.
REQ-002 SHALL have parameter MEMSIZE, default 25, line width in bits (SIZE*SIZE).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port go  input  1  request to begin a load (sampled in IDLE only).
REQ-006 SHALL have port cfg_count  input  6  number of lines to load; 0 means 64.
REQ-007 SHALL have port in_valid  input  1  upstream line valid.
REQ-008 SHALL have port in_line  input  MEMSIZE  upstream line data.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_line this cycle.
REQ-010 SHALL have port mem_we  output  1  line-memory write strobe.
REQ-011 SHALL have port mem_addr  output  6  line-memory write address.
REQ-012 SHALL have port mem_wdata  output  MEMSIZE  line-memory write data.
REQ-013 SHALL have port start  output  1  one-cycle pulse launching the downstream rotation controller.
REQ-014 SHALL have port count  output  6  latched line count presented to the downstream controller.
REQ-015 SHALL have port done  input  1  downstream controller finished.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port loaded  output  1  one-cycle pulse when done is observed in WAIT.

Function
REQ-018 SHALL implement states IDLE, LOAD, KICK, WAIT.
REQ-019 IDLE: go=1 SHALL latch cfg_count into count, clear addr to 0, go to LOAD next cycle; go outside IDLE SHALL be ignored.
REQ-020 LOAD: in_ready SHALL be 1; an accepted line (in_valid&in_ready) SHALL drive mem_we=1, mem_addr=addr, mem_wdata=in_line combinationally in that same cycle, and addr SHALL increment by 1 (6-bit).
REQ-021 LOAD: the accept at addr==count-1 (mod 64, so count 0 ends at addr 63) SHALL move to KICK; addr wrap 63->0 SHALL occur only on that final accept.
REQ-022 LOAD with in_valid=0 SHALL hold state and addr, mem_we=0.
REQ-023 KICK: start=1 for exactly one cycle, in_ready=0, then WAIT.
REQ-024 WAIT: in_ready=0, mem_we=0; done=1 SHALL pulse loaded for one cycle and return to IDLE; done in any other state SHALL be ignored.
REQ-025 count SHALL remain stable from the go cycle until IDLE is re-entered.
REQ-026 A new go SHALL be accepted in the first IDLE cycle after WAIT (back-to-back loads, no dead cycle beyond IDLE).
REQ-027 in_ready, mem_we, start and loaded SHALL be 0 in IDLE.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, addr=0, count=0, and all outputs 0, regardless of current state, including mid-LOAD.
REQ-029 After rst deassertion the first go SHALL begin a fresh load; no partial-load state survives.

Configuration
REQ-030 Macro SLICE_LOADER_PARITY_EN defined: SHALL add input in_parity (1 bit, even parity of in_line) and output par_err (1 bit, sticky); any accepted line whose XOR-reduction differs from in_parity SHALL set par_err on the next edge; par_err clears on rst or on an accepted go.
REQ-031 Macro not defined: in_parity and par_err SHALL not exist and no parity logic SHALL be built; all other behaviour identical.

Verification
REQ-032 Reset, go=1 cfg_count=3, three lines 0x0000001/0x1555555/0x1FFFFFF with in_valid held -> writes at addr 0,1,2 in consecutive cycles, start pulse one cycle after third write, count=3.
REQ-033 cfg_count=4 with in_valid toggling 1,0,1,0... -> mem_we only on valid cycles, addr sequence 0..3, no extra write, KICK after fourth accept.
REQ-034 cfg_count=0 -> exactly 64 writes addr 0..63, then start; count output reads 0.
REQ-035 In WAIT, drive go=1 and in_valid=1 -> no writes, no state change; then done=1 -> loaded pulse, IDLE; go next cycle accepted.
REQ-036 rst=0 asserted after 2 of 5 lines -> outputs 0 immediately (before clock edge), next go restarts at addr 0.
REQ-037 With SLICE_LOADER_PARITY_EN: line 0x0000003 with in_parity=1 -> par_err=1 next cycle and stays 1 through WAIT; next go clears it.
